brg_xcel_master_arbiter: RTL and testbench
==========================================

# brg_xcel_master_arbiter

Shares the single manycore endpoint master port (request valid/ready, always-accepted response) among `num_req_p` accelerator master ports inside one BRG accelerator tile. It arbitrates requests round-robin. For loads, it tags the requester index into the upper bits of the load ID and routes each returned load back to its owner by that tag. It enforces a per-requester limit on outstanding loads and flags responses that arrive with no matching outstanding load.

## Interface
Parameters:
- `num_req_p`, 4: number of requester ports; power of two, ≥2.
- `data_width_p`, 32: data width.
- `addr_width_p`, 32: address width.
- `load_id_width_p`, 11: endpoint load-ID width.
- `max_outstanding_p`, 8: maximum outstanding loads per requester, ≥1.
- Derived `id_width_lp` = clog2(`num_req_p`).
- Derived `opq_width_lp` = `load_id_width_p` − `id_width_lp`.
- Derived `cnt_width_lp` = clog2(`max_outstanding_p`+1).

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `req_v_i` in `num_req_p`: per-requester request valid.
- `req_type_i` in `num_req_p`: 1 = store, 0 = load.
- `req_addr_i` in `num_req_p`×`addr_width_p`: request addresses, requester r at slice r.
- `req_data_i` in `num_req_p`×`data_width_p`: store data.
- `req_mask_i` in `num_req_p`×(`data_width_p`/8): byte masks.
- `req_opq_i` in `num_req_p`×`opq_width_lp`: requester-local load tag.
- `req_rdy_o` out `num_req_p`: request accepted when `req_v_i[r]` & `req_rdy_o[r]`.
- `out_v_o` out 1: request to the endpoint.
- `out_type_o` out 1: request type.
- `out_addr_o` out `addr_width_p`: request address.
- `out_data_o` out `data_width_p`: store data.
- `out_mask_o` out `data_width_p`/8: byte mask.
- `out_opq_o` out `load_id_width_p`: {grantee index, `req_opq_i`[grantee]}.
- `out_rdy_i` in 1: endpoint ready.
- `ret_v_i` in 1: returned load valid; always consumed.
- `ret_data_i` in `data_width_p`: returned data.
- `ret_opq_i` in `load_id_width_p`: returned load ID.
- `ret_v_o` out `num_req_p`: one-hot response valid.
- `ret_data_o` out `data_width_p`: response data, broadcast to all requesters.
- `ret_opq_o` out `opq_width_lp`: `ret_opq_i` low bits.
- `err_o` out 1: sticky protocol error.

## Operation
- Eligibility: requester r is eligible iff `req_v_i[r]` and either (a) the request is a store, or (b) `cnt[r]` < `max_outstanding_p`.
- Arbitration: round-robin over eligible requesters. Search starts at `last_r`+1 mod `num_req_p`.
- Lock: if `out_v_o` is high and `out_rdy_i` is low, set `lock_v_r`=1 and `lock_id_r`=grantee. While locked, the grant is forced to `lock_id_r`, regardless of other requesters. The lock clears on handshake.
- Requester rule: a requester keeps its valid and payload stable until accepted. Violations are not checked.
- Outputs: `out_v_o` = any grant. Payload is muxed from the grantee. `req_rdy_o[g]` = `out_rdy_i` for grantee g; all other bits are 0.
- Handshake (`out_v_o` & `out_rdy_i`): set `last_r` to the grantee. If the request is a load, increment `cnt[g]`.
- Response: id = `ret_opq_i[load_id_width_p-1 -: id_width_lp]`. Drive `ret_v_o[id]` = `ret_v_i`. Decrement `cnt[id]`.
- Response to an idle requester: if `cnt[id]`==0 when a response arrives, set `err_o`, leave the counter at 0, and still drive `ret_v_o[id]`.
- Simultaneous increment and decrement of the same counter: the value is unchanged.
- Counter limit: `cnt` never exceeds `max_outstanding_p`, because eligibility masks the requester once the limit is reached.
- Stores pass straight through. `out_opq_o` carries the tag, but stores are not counted.
- Reset (asynchronous assert, any time): `last_r`=`num_req_p`−1 (so requester 0 has first priority), `lock_v_r`=0, all `cnt`=0, `err_o`=0. In-flight tags are discarded. Responses arriving after reset for pre-reset loads raise `err_o`.

## Timing
- Request path is combinational: `req_*` → `out_*` and `out_rdy_i` → `req_rdy_o`, zero latency.
- Response path is combinational, zero latency.
- State updates on `clk_i` rising edge: `last_r`, lock, counters, `err_o`.
- While `reset_i`=0: `out_v_o`=0, `req_rdy_o`=0, `ret_v_o`=0, `err_o`=0. `out_*` payload and `ret_data_o`/`ret_opq_o` are don't-care.
- Throughput: one request per cycle. A requester that is continuously valid is granted at least once every `num_req_p` handshakes.
- An eligibility change caused by this cycle's response takes effect next cycle (counters are registered).

## Structure
- Shared package `brg_xcel_pkg`:
  - `req_type_e` {LOAD=0, STORE=1}.
  - Packed struct `xcel_req_s` {type, addr, data, mask, opq}.
  - Tag helper functions: pack id+opq, extract id.
- Sub-module `brg_rr_arb` (`num_req_p` inputs, lock input, one-hot grant, `last_r` register).
- Counters and error logic live in the top module.

## Test plan
- Requester 1 issues a single load, opq=9'h05, `out_rdy_i`=1 → `out_opq_o`=11'h205 same cycle, `cnt[1]`=1. A response with `ret_opq_i`=11'h205 → `ret_v_o`=4'b0010, `ret_opq_o`=9'h05, `cnt[1]`=0.
- All four requesters valid, `out_rdy_i`=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3.
- Requester 2 granted, `out_rdy_i`=0 for 3 cycles while requester 0 asserts valid → `out_addr_o` stays requester 2's address, `req_rdy_o`=0. After `out_rdy_i` rises, requester 2 is accepted, then requester 0.
- Requester 0 issues 8 loads with no responses (`max_outstanding_p`=8) → 9th load is blocked (`req_rdy_o[0]`=0) while a requester 0 store and requester 1 loads still pass. Same-cycle handshake on requester 0 plus a response for requester 0 → `cnt[0]` unchanged.
- Response with id 3 while `cnt[3]`=0 → `err_o`=1 next cycle and stays 1. Asserting `reset_i` low mid-stream → `cnt` cleared, `err_o`=0, `out_v_o`=0 immediately.

Source files
------------

// File: rtl/brg_xcel_pkg.sv
// Shared types and load-tag helpers for the BRG accelerator master arbiter.
// The tag is {requester index, requester-local opaque bits}.
package brg_xcel_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } req_type_e;

    localparam int XCEL_ADDR_W = 32;
    localparam int XCEL_DATA_W = 32;
    localparam int XCEL_OPQ_W  = 9;
    localparam int TAG_MAX_W   = 32;

    // Request payload in the default tile configuration.
    typedef struct packed {
        req_type_e                  req_type;
        logic [XCEL_ADDR_W-1:0]     addr;
        logic [XCEL_DATA_W-1:0]     data;
        logic [XCEL_DATA_W/8-1:0]   mask;
        logic [XCEL_OPQ_W-1:0]      opq;
    } xcel_req_s;

    function automatic logic [TAG_MAX_W-1:0] tag_pack(
        input logic [TAG_MAX_W-1:0] id,
        input logic [TAG_MAX_W-1:0] opq,
        input int                   opq_w
    );
        return (id << opq_w) | opq;
    endfunction

    // Caller passes a tag zero-extended from load_id_width_p bits.
    function automatic logic [TAG_MAX_W-1:0] tag_id(
        input logic [TAG_MAX_W-1:0] tag,
        input int                   opq_w
    );
        return tag >> opq_w;
    endfunction

endpackage

// File: rtl/brg_xcel_master_arbiter_arb.sv
// Round-robin arbiter with a priority pointer and an external grant lock.
// The pointer only advances on an accepted request.
module brg_rr_arb #(
    parameter int num_req_p = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [num_req_p-1:0]         eligible,
    input  logic                         lock_v,
    input  logic [$clog2(num_req_p)-1:0] lock_id,
    input  logic                         advance,
    output logic                         grant_v,
    output logic [$clog2(num_req_p)-1:0] grant_id,
    output logic [num_req_p-1:0]         grant_oh
);
    localparam int id_width_lp = $clog2(num_req_p);

    logic [id_width_lp-1:0] last_r;
    logic [id_width_lp-1:0] idx;
    logic [id_width_lp-1:0] pick;
    logic                   found;

    // num_req_p is a power of two, so the pointer wraps by plain truncation.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx = last_r + id_width_lp'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (lock_v) begin
            found = 1'b1;
            pick  = lock_id;
        end
    end

    always_comb begin
        grant_v  = found;
        grant_id = pick;
        grant_oh = '0;
        if (found) begin
            grant_oh[pick] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= id_width_lp'(num_req_p - 1);
        end else if (advance) begin
            last_r <= pick;
        end
    end

endmodule

// File: rtl/brg_xcel_master_arbiter.sv
// Shares one endpoint master port among accelerator requesters: round-robin
// request arbitration, tagged load routing, per-requester outstanding-load limit.
module brg_xcel_master_arbiter
    import brg_xcel_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int load_id_width_p   = 11,
    parameter int max_outstanding_p = 8
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic [num_req_p-1:0]                                  req_v_i,
    input  logic [num_req_p-1:0]                                  req_type_i,
    input  logic [num_req_p*addr_width_p-1:0]                     req_addr_i,
    input  logic [num_req_p*data_width_p-1:0]                     req_data_i,
    input  logic [num_req_p*(data_width_p/8)-1:0]                 req_mask_i,
    input  logic [num_req_p*(load_id_width_p-$clog2(num_req_p))-1:0] req_opq_i,
    output logic [num_req_p-1:0]                                  req_rdy_o,
    output logic                                                  out_v_o,
    output logic                                                  out_type_o,
    output logic [addr_width_p-1:0]                               out_addr_o,
    output logic [data_width_p-1:0]                               out_data_o,
    output logic [data_width_p/8-1:0]                             out_mask_o,
    output logic [load_id_width_p-1:0]                            out_opq_o,
    input  logic                                                  out_rdy_i,
    input  logic                                                  ret_v_i,
    input  logic [data_width_p-1:0]                               ret_data_i,
    input  logic [load_id_width_p-1:0]                            ret_opq_i,
    output logic [num_req_p-1:0]                                  ret_v_o,
    output logic [data_width_p-1:0]                               ret_data_o,
    output logic [load_id_width_p-$clog2(num_req_p)-1:0]          ret_opq_o,
    output logic                                                  err_o
);
    localparam int id_width_lp   = $clog2(num_req_p);
    localparam int opq_width_lp  = load_id_width_p - id_width_lp;
    localparam int cnt_width_lp  = $clog2(max_outstanding_p + 1);
    localparam int mask_width_lp = data_width_p / 8;
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_outstanding_p);

    logic [num_req_p-1:0]    eligible;
    logic [num_req_p-1:0]    grant_oh;
    logic [id_width_lp-1:0]  grant_id;
    logic                    grant_v;
    logic                    hs;
    logic                    lock_v_r;
    logic [id_width_lp-1:0]  lock_id_r;
    logic [id_width_lp-1:0]  ret_id;
    logic                    resp_idle;
    logic                    err_r;
    logic [num_req_p-1:0]    cnt_inc;
    logic [num_req_p-1:0]    cnt_dec;
    logic [cnt_width_lp-1:0] cnt_r [num_req_p];

    always_comb begin
        eligible = '0;
        for (int r = 0; r < num_req_p; r++) begin
            eligible[r] = req_v_i[r] &&
                          ((req_type_e'(req_type_i[r]) == STORE) || (cnt_r[r] < cnt_max_lp));
        end
    end

    brg_rr_arb #(
        .num_req_p (num_req_p)
    ) u_arb (
        .clk      (clk_i),
        .reset_n  (reset_i),
        .eligible (eligible),
        .lock_v   (lock_v_r),
        .lock_id  (lock_id_r),
        .advance  (hs),
        .grant_v  (grant_v),
        .grant_id (grant_id),
        .grant_oh (grant_oh)
    );

    // Request path: purely combinational mux from the grantee, gated by reset.
    assign out_v_o    = grant_v & reset_i;
    assign hs         = out_v_o & out_rdy_i;
    assign req_rdy_o  = grant_oh & {num_req_p{out_rdy_i & reset_i}};
    assign out_type_o = req_type_i[grant_id];
    assign out_addr_o = req_addr_i[grant_id*addr_width_p +: addr_width_p];
    assign out_data_o = req_data_i[grant_id*data_width_p +: data_width_p];
    assign out_mask_o = req_mask_i[grant_id*mask_width_lp +: mask_width_lp];
    assign out_opq_o  = load_id_width_p'(tag_pack(TAG_MAX_W'(grant_id),
                            TAG_MAX_W'(req_opq_i[grant_id*opq_width_lp +: opq_width_lp]),
                            opq_width_lp));

    // Response path: route by the tag's index field, broadcast data.
    assign ret_id     = id_width_lp'(tag_id(TAG_MAX_W'(ret_opq_i), opq_width_lp));
    assign ret_data_o = ret_data_i;
    assign ret_opq_o  = ret_opq_i[opq_width_lp-1:0];
    assign resp_idle  = ret_v_i && (cnt_r[ret_id] == '0);
    assign err_o      = err_r;

    always_comb begin
        ret_v_o = '0;
        if (ret_v_i && reset_i) begin
            ret_v_o[ret_id] = 1'b1;
        end
    end

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int r = 0; r < num_req_p; r++) begin
            cnt_inc[r] = hs && (grant_id == id_width_lp'(r)) &&
                         (req_type_e'(out_type_o) == LOAD);
            cnt_dec[r] = ret_v_i && (ret_id == id_width_lp'(r)) && (cnt_r[r] != '0);
        end
    end

    // Increment and decrement in the same cycle cancel.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int r = 0; r < num_req_p; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < num_req_p; r++) begin
                if (cnt_inc[r] && !cnt_dec[r]) begin
                    cnt_r[r] <= cnt_r[r] + 1'b1;
                end else if (!cnt_inc[r] && cnt_dec[r]) begin
                    cnt_r[r] <= cnt_r[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            lock_v_r  <= 1'b0;
            lock_id_r <= '0;
        end else if (out_v_o && !out_rdy_i) begin
            lock_v_r  <= 1'b1;
            lock_id_r <= grant_id;
        end else if (hs) begin
            lock_v_r  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_r <= 1'b0;
        end else if (resp_idle) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_brg_xcel_master_arbiter.sv
// Scoreboard bench for brg_xcel_master_arbiter: expected requests and
// responses are queued when driven and compared as the DUT presents them.
module tb_brg_xcel_master_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 11;
    localparam int MO = 8;
    localparam int OW = 9;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_v, req_type, req_rdy;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*4-1:0]    req_mask;
    logic [N*OW-1:0]   req_opq;
    logic              out_v, out_type, out_rdy;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_mask;
    logic [LW-1:0]     out_opq;
    logic              ret_v_in;
    logic [DW-1:0]     ret_data_in;
    logic [LW-1:0]     ret_opq_in;
    logic [N-1:0]      ret_v_out;
    logic [DW-1:0]     ret_data_out;
    logic [OW-1:0]     ret_opq_out;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [LW-1:0] opq;
        logic          typ;
    } req_exp_t;

    typedef struct {
        logic [N-1:0]  v;
        logic [OW-1:0] opq;
        logic [DW-1:0] data;
    } ret_exp_t;

    req_exp_t req_q[$];
    ret_exp_t ret_q[$];

    always #5 clk = ~clk;

    brg_xcel_master_arbiter #(
        .num_req_p(N), .data_width_p(DW), .addr_width_p(AW),
        .load_id_width_p(LW), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v), .req_type_i(req_type), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_mask_i(req_mask), .req_opq_i(req_opq),
        .req_rdy_o(req_rdy),
        .out_v_o(out_v), .out_type_o(out_type), .out_addr_o(out_addr),
        .out_data_o(out_data), .out_mask_o(out_mask), .out_opq_o(out_opq),
        .out_rdy_i(out_rdy),
        .ret_v_i(ret_v_in), .ret_data_i(ret_data_in), .ret_opq_i(ret_opq_in),
        .ret_v_o(ret_v_out), .ret_data_o(ret_data_out), .ret_opq_o(ret_opq_out),
        .err_o(err)
    );

    function automatic logic [AW-1:0] addr_of(input int r);
        return 32'h1000_0000 + 32'(r) * 32'h40;
    endfunction

    function automatic logic [DW-1:0] data_of(input int r);
        return 32'hD000_0000 + 32'(r);
    endfunction

    task automatic drive_req(input int r, input logic v, input logic typ, input logic [OW-1:0] opq);
        req_v[r]             = v;
        req_type[r]          = typ;
        req_addr[r*AW +: AW] = addr_of(r);
        req_data[r*DW +: DW] = data_of(r);
        req_mask[r*4 +: 4]   = 4'hF;
        req_opq[r*OW +: OW]  = opq;
    endtask

    task automatic push_req(input int r, input logic typ, input logic [OW-1:0] opq);
        req_q.push_back(req_exp_t'{addr_of(r), data_of(r), {2'(r), opq}, typ});
    endtask

    task automatic clear_inputs();
        req_v = '0; req_type = '0; req_addr = '0; req_data = '0;
        req_mask = '0; req_opq = '0; out_rdy = 1'b0;
        ret_v_in = 1'b0; ret_data_in = '0; ret_opq_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        clear_inputs();
        req_v = '1; out_rdy = 1'b1; ret_v_in = 1'b1;
        #2;
        n_tests++;
        if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b want 0", out_v); end
        n_tests++;
        if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); end
        n_tests++;
        if (ret_v_out !== 4'b0000) begin n_fail++; $display("FAIL reset_ret_v: got %b want 0000", ret_v_out); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        clear_inputs();
        tick();
        reset_i = 1'b1;
    endtask

    task automatic test_single_load();
        req_exp_t e;
        ret_exp_t re;
        out_rdy = 1'b1;
        drive_req(1, 1'b1, 1'b0, 9'h05);
        push_req(1, 1'b0, 9'h05);
        @(negedge clk);
        n_tests++;
        if (out_opq !== 11'h205) begin n_fail++; $display("FAIL single_opq: got %h want 205", out_opq); end
        n_tests++;
        if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL single_rdy: got %b want 0010", req_rdy); end
        n_tests++;
        if (!(out_v && out_rdy) || req_q.size() == 0) begin
            n_fail++; $display("FAIL single_hs: out_v=%b, want handshake", out_v);
        end else begin
            e = req_q.pop_front();
            if (out_addr !== e.addr || out_opq !== e.opq || out_type !== e.typ || out_data !== e.data) begin
                n_fail++; $display("FAIL single_sb: got addr %h opq %h want addr %h opq %h", out_addr, out_opq, e.addr, e.opq);
            end
        end
        tick();
        drive_req(1, 1'b0, 1'b0, 9'h05);
        n_tests++;
        if (dut.cnt_r[1] !== 4'd1) begin n_fail++; $display("FAIL single_cnt_inc: got %0d want 1", dut.cnt_r[1]); end
        ret_v_in = 1'b1; ret_opq_in = 11'h205; ret_data_in = 32'hCAFE_0001;
        ret_q.push_back(ret_exp_t'{4'b0010, 9'h05, 32'hCAFE_0001});
        @(negedge clk);
        n_tests++;
        if (ret_v_out == '0 || ret_q.size() == 0) begin
            n_fail++; $display("FAIL single_ret: got ret_v %b want 0010", ret_v_out);
        end else begin
            re = ret_q.pop_front();
            if (ret_v_out !== re.v || ret_opq_out !== re.opq || ret_data_out !== re.data) begin
                n_fail++; $display("FAIL single_ret: got %b/%h/%h want %b/%h/%h", ret_v_out, ret_opq_out, ret_data_out, re.v, re.opq, re.data);
            end
        end
        tick();
        ret_v_in = 1'b0;
        n_tests++;
        if (dut.cnt_r[1] !== 4'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL single_cnt_dec: got cnt %0d err %b want 0 0", dut.cnt_r[1], err);
        end
    endtask

    task automatic test_round_robin();
        req_exp_t e;
        reset_pulse();
        out_rdy = 1'b1;
        for (int r = 0; r < N; r++) drive_req(r, 1'b1, 1'b0, 9'(r));
        for (int i = 0; i < 8; i++) push_req(i % N, 1'b0, 9'(i % N));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (!(out_v && out_rdy) || req_q.size() == 0) begin
                n_fail++; $display("FAIL rr_hs[%0d]: out_v=%b, want handshake", i, out_v);
            end else begin
                e = req_q.pop_front();
                if (out_addr !== e.addr || out_opq !== e.opq || req_rdy !== (4'b0001 << (i % N))) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got addr %h rdy %b want addr %h rdy %b", i, out_addr, req_rdy, e.addr, 4'b0001 << (i % N));
                end
            end
            tick();
        end
        req_v = '0;
        for (int r = 0; r < N; r++) begin
            n_tests++;
            if (dut.cnt_r[r] !== 4'd2) begin n_fail++; $display("FAIL rr_cnt[%0d]: got %0d want 2", r, dut.cnt_r[r]); end
        end
    endtask

    task automatic test_lock();
        req_exp_t e;
        out_rdy = 1'b0;
        drive_req(2, 1'b1, 1'b1, 9'h22);
        push_req(2, 1'b1, 9'h22);
        @(negedge clk);
        n_tests++;
        if (out_v !== 1'b1 || out_addr !== addr_of(2)) begin
            n_fail++; $display("FAIL lock_first: got v %b addr %h want 1 %h", out_v, out_addr, addr_of(2));
        end
        tick();
        drive_req(0, 1'b1, 1'b1, 9'h11);
        push_req(0, 1'b1, 9'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_v !== 1'b1 || out_addr !== addr_of(2) || req_rdy !== 4'b0000) begin
                n_fail++; $display("FAIL lock_hold[%0d]: got v %b addr %h rdy %b want 1 %h 0000", i, out_v, out_addr, req_rdy, addr_of(2));
            end
            tick();
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (!(out_v && out_rdy) || req_q.size() == 0) begin
                n_fail++; $display("FAIL lock_hs[%0d]: out_v=%b, want handshake", i, out_v);
            end else begin
                e = req_q.pop_front();
                if (out_addr !== e.addr || out_opq !== e.opq) begin
                    n_fail++; $display("FAIL lock_order[%0d]: got addr %h opq %h want %h %h", i, out_addr, out_opq, e.addr, e.opq);
                end
            end
            tick();
            if (i == 0) drive_req(2, 1'b0, 1'b1, 9'h22);
            else        drive_req(0, 1'b0, 1'b1, 9'h11);
        end
    endtask

    task automatic test_outstanding();
        req_exp_t e;
        ret_exp_t re;
        reset_pulse();
        out_rdy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            // 0-7: loads, 8: blocked load, 9: store, 10: r1 load, 11: response, 12: load+response
            ret_v_in = 1'b0;
            if (i < 8) begin
                drive_req(0, 1'b1, 1'b0, 9'(i)); push_req(0, 1'b0, 9'(i));
            end else if (i == 8) begin
                drive_req(0, 1'b1, 1'b0, 9'h0F);
            end else if (i == 9) begin
                drive_req(0, 1'b1, 1'b1, 9'h0F); push_req(0, 1'b1, 9'h0F);
            end else if (i == 10) begin
                drive_req(0, 1'b1, 1'b0, 9'h0F);
                drive_req(1, 1'b1, 1'b0, 9'h01); push_req(1, 1'b0, 9'h01);
            end else begin
                drive_req(1, 1'b0, 1'b0, 9'h01);
                ret_v_in = 1'b1; ret_opq_in = {2'b00, 9'(i)}; ret_data_in = 32'hBEEF_0000 + 32'(i);
                ret_q.push_back(ret_exp_t'{4'b0001, 9'(i), 32'hBEEF_0000 + 32'(i)});
                if (i == 12) push_req(0, 1'b0, 9'h0F);
            end
            @(negedge clk);
            if (i == 8 || i == 11) begin
                n_tests++;
                if (out_v !== 1'b0 || req_rdy[0] !== 1'b0) begin
                    n_fail++; $display("FAIL limit_block[%0d]: got v %b rdy %b want 0 0", i, out_v, req_rdy);
                end
            end else begin
                n_tests++;
                if (!(out_v && out_rdy) || req_q.size() == 0) begin
                    n_fail++; $display("FAIL limit_hs[%0d]: out_v=%b, want handshake", i, out_v);
                end else begin
                    e = req_q.pop_front();
                    if (out_addr !== e.addr || out_opq !== e.opq || out_type !== e.typ) begin
                        n_fail++; $display("FAIL limit_sb[%0d]: got %h/%h/%b want %h/%h/%b", i, out_addr, out_opq, out_type, e.addr, e.opq, e.typ);
                    end
                end
            end
            if (i >= 11) begin
                n_tests++;
                if (ret_q.size() == 0) begin
                    n_fail++; $display("FAIL limit_ret[%0d]: got ret_v %b, nothing expected", i, ret_v_out);
                end else begin
                    re = ret_q.pop_front();
                    if (ret_v_out !== re.v || ret_opq_out !== re.opq || ret_data_out !== re.data) begin
                        n_fail++; $display("FAIL limit_ret[%0d]: got %b/%h want %b/%h", i, ret_v_out, ret_opq_out, re.v, re.opq);
                    end
                end
            end
            tick();
            if (i == 7 || i == 10) begin
                n_tests++;
                if (dut.cnt_r[0] !== 4'd8) begin n_fail++; $display("FAIL limit_cnt8[%0d]: got %0d want 8", i, dut.cnt_r[0]); end
            end
        end
        ret_v_in = 1'b0;
        drive_req(0, 1'b0, 1'b0, 9'h0F);
        n_tests++;
        if (dut.cnt_r[0] !== 4'd7 || dut.cnt_r[1] !== 4'd1 || err !== 1'b0) begin
            n_fail++; $display("FAIL limit_cancel: got cnt0 %0d cnt1 %0d err %b want 7 1 0", dut.cnt_r[0], dut.cnt_r[1], err);
        end
    endtask

    task automatic test_error();
        ret_exp_t re;
        ret_v_in = 1'b1; ret_opq_in = {2'b11, 9'h001}; ret_data_in = 32'h0BAD_0003;
        ret_q.push_back(ret_exp_t'{4'b1000, 9'h001, 32'h0BAD_0003});
        @(negedge clk);
        n_tests++;
        re = ret_q.pop_front();
        if (ret_v_out !== re.v || ret_opq_out !== re.opq || err !== 1'b0) begin
            n_fail++; $display("FAIL err_ret: got %b/%h err %b want %b/%h err 0", ret_v_out, ret_opq_out, err, re.v, re.opq);
        end
        tick();
        ret_v_in = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        tick();
        n_tests++;
        if (err !== 1'b1 || dut.cnt_r[3] !== 4'd0) begin
            n_fail++; $display("FAIL err_sticky: got err %b cnt3 %0d want 1 0", err, dut.cnt_r[3]);
        end
    endtask

    task automatic test_reset_mid();
        req_exp_t e;
        ret_exp_t re;
        out_rdy = 1'b1;
        drive_req(1, 1'b1, 1'b0, 9'h07);
        push_req(1, 1'b0, 9'h07);
        @(negedge clk);
        n_tests++;
        if (!(out_v && out_rdy) || req_q.size() == 0) begin
            n_fail++; $display("FAIL mid_hs: out_v=%b, want handshake", out_v);
        end else begin
            e = req_q.pop_front();
            if (out_addr !== e.addr || out_opq !== e.opq) begin
                n_fail++; $display("FAIL mid_sb: got %h/%h want %h/%h", out_addr, out_opq, e.addr, e.opq);
            end
        end
        #1;
        reset_i = 1'b0;
        #1;
        n_tests++;
        if (out_v !== 1'b0 || req_rdy !== 4'b0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_out: got v %b rdy %b err %b want 0 0000 0", out_v, req_rdy, err);
        end
        for (int r = 0; r < N; r++) begin
            n_tests++;
            if (dut.cnt_r[r] !== 4'd0) begin n_fail++; $display("FAIL mid_reset_cnt[%0d]: got %0d want 0", r, dut.cnt_r[r]); end
        end
        clear_inputs();
        tick();
        reset_i = 1'b1;
        ret_v_in = 1'b1; ret_opq_in = {2'b01, 9'h07}; ret_data_in = 32'h5A5A_0001;
        ret_q.push_back(ret_exp_t'{4'b0010, 9'h07, 32'h5A5A_0001});
        @(negedge clk);
        n_tests++;
        re = ret_q.pop_front();
        if (ret_v_out !== re.v || ret_data_out !== re.data) begin
            n_fail++; $display("FAIL stale_ret: got %b/%h want %b/%h", ret_v_out, ret_data_out, re.v, re.data);
        end
        tick();
        ret_v_in = 1'b0;
        n_tests++;
        if (err !== 1'b1 || dut.cnt_r[1] !== 4'd0) begin
            n_fail++; $display("FAIL stale_err: got err %b cnt1 %0d want 1 0", err, dut.cnt_r[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_error();
        test_reset_mid();
        n_tests++;
        if (req_q.size() != 0 || ret_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d/%0d left want 0/0", req_q.size(), ret_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
